// File: rtl/tpm_access_ctrl.sv
// Request-side scheduler for the 1RW1R SRAM macro: A owns the read port, C/B share the RW port.
// Optional build macro TPM_RAW_BYPASS_EN forwards same-address C write data to a colliding A read.
module tpm_access_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              mem_r_valid,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_rw_valid,
    output logic              mem_rw_w_en,
    output logic [ADDR_W-1:0] mem_rw_addr,
    output logic [DATA_W-1:0] mem_rw_data_in,
    input  logic [DATA_W-1:0] mem_rw_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve;
    logic       a_pend;
    logic       b_pend;
    logic       at_limit;
    logic       force_b;
    logic       c_grant;
    logic       b_acc;
    logic       a_acc;
    logic       collide;

    // Request side: grants and macro drive are combinational from valids and state
    always_comb begin
        at_limit = (starve == LIMIT);
        force_b  = b_valid && at_limit;
        c_ready  = !rst && !force_b;
        c_grant  = c_valid && c_ready;
        // b_ready uses the limit alone so it never depends on b_valid
        b_ready  = !rst && (at_limit || !c_valid);
        b_acc    = b_valid && b_ready;
        collide  = c_grant && (c_addr == a_addr);
`ifdef TPM_RAW_BYPASS_EN
        a_ready  = !rst;
`else
        a_ready  = !rst && !collide;
`endif
        a_acc    = a_valid && a_ready;

        mem_r_valid    = a_acc;
        mem_r_addr     = a_addr;
        mem_rw_valid   = c_grant || b_acc;
        mem_rw_w_en    = c_grant;
        mem_rw_addr    = c_grant ? c_addr : b_addr;
        mem_rw_data_in = c_wdata;
    end

    // Response side: one-cycle pending flags and the fairness counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
            a_pend <= 1'b0;
            b_pend <= 1'b0;
        end else begin
            a_pend <= a_acc;
            b_pend <= b_acc;
            if (!b_valid || b_acc)
                starve <= '0;
            else if (c_grant && !at_limit)
                starve <= starve + 4'd1;
        end
    end

    assign a_rvalid = a_pend;
    assign b_rvalid = b_pend;
    assign b_rdata  = mem_rw_data;

`ifdef TPM_RAW_BYPASS_EN
    logic              a_byp;
    logic [DATA_W-1:0] byp_data;

    // The macro's read result is undefined on a collision, so the write data is replayed instead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_byp    <= 1'b0;
            byp_data <= '0;
        end else begin
            a_byp <= a_acc && collide;
            if (a_acc && collide)
                byp_data <= c_wdata;
        end
    end

    assign a_rdata = a_byp ? byp_data : mem_r_data;
`else
    assign a_rdata = mem_r_data;
`endif

endmodule
